cic3_decimator: RTL and testbench
=================================

Name: cic3_decimator

Overview:
- Third-order CIC (sinc^3) decimation filter for the 1-bit sigma-delta modulator bitstream.
- Decimation ratio R = 256, differential delay M = 1.
- Produces a 25-bit unsigned decimated sample.
- A 4-bit digital monitor select routes either the filter result or internal nodes onto the same output bus for debug.

Parameters:
- ORDER, 3, number of integrator and comb stages (fixed; RTL written for 3).
- DECIM_LOG2, 8, log2 of decimation ratio (R = 256).
- OUT_W, 25, output/accumulator width = 1 + ORDER*DECIM_LOG2.

Ports:
- clk  input  1  single system clock; the modulator rate, one input bit per cycle.
- reset  input  1  synchronous, active-high reset.
- in  input  1  modulator bitstream; 1 = +full-scale, 0 = zero (unsigned 0/1 weighting).
- digital_monitor_sel  input  4  selects what drives out.
- out  output  25  selected data, unsigned.

Behaviour:
- Reset (sampled on rising clk while reset=1):
  - Clear all integrators, comb delay registers, decimation counter, output register.
  - out = 0 for every select value.
- Decimation counter: cnt[7:0] increments every clk after reset, wraps 255->0. Strobe = (cnt == 255).
- Integrators, every clk, OUT_W-bit modulo-2^25 wrap arithmetic (wrap is required and correct for CIC):
  - i1 <= i1 + in
  - i2 <= i2 + i1
  - i3 <= i3 + i2
  - Each uses the registered values of the previous cycle.
- Combs, evaluated only on strobe, all modulo 2^25:
  - c1 = i3 - d1
  - c2 = c1 - d2
  - c3 = c2 - d3
  - Same edge updates d1 <= i3, d2 <= c1, d3 <= c2, y <= c3.
  - Delay registers and y hold between strobes.
- Filter output y:
  - Updates one clk after the strobe edge; holds for 256 cycles.
  - Steady-state gain R^3 = 2^24: constant in=1 gives y = 16777216 (0x1000000), which fits exactly in 25 bits without overflow.
  - The first 3 updates after reset are transient; from the 4th update onward y is exact for constant input.
- digital_monitor_sel mapping (out is driven from a register):
  - 0: y
  - 1/2/3: i1/i2/i3
  - 4/5/6: d1/d2/d3
  - 7: cnt zero-extended
  - 8: {24'b0, in} registered
  - 9..15: 0
- Select change takes effect on the next clk edge; the filter state is unaffected.
- Reset asserted mid-operation:
  - Full clear on that edge, no partial sample emitted.
  - Counter restarts at 0, so the first strobe after release is 256 cycles later.
- Input X/Z is not handled; the bench must drive 0/1 only.

Decomposition:
- Package cic3_pkg:
  - Constants ORDER = 3, DECIM_LOG2 = 8, OUT_W = 25, R = 256.
  - typedef logic [OUT_W-1:0] cic_word_t.
  - enum of monitor select codes: MON_OUT = 0, MON_I1, MON_I2, MON_I3, MON_D1, MON_D2, MON_D3, MON_CNT, MON_IN.
- One natural sub-module, cic_integrator:
  - Registered accumulator of width OUT_W with synchronous reset.
  - Instantiated 3x in cascade.
- Combs, counter and monitor mux stay in the top module.

Test Plan:
- All-zero input, sel=0, 5000 cycles after reset release -> out = 0 throughout.
- Constant in=1, sel=0 -> out updates once per 256 clk; from the 4th update onward out = 16777216, stable.
- Alternating 1,0 bitstream, sel=0 -> steady-state out = 8388608.
- Constant in=1, sel=7 -> out counts 0..255 and wraps. With sel=1, out increments by 1 per clk and wraps at 2^25. With sel=9..15, out = 0.
- Sine-driven sigma-delta stream (50 MHz clk, low-frequency sine) -> sel=0 output is a sampled sine centred near 2^23, bounded within 0..2^24, updated every 256 cycles.
- Reset pulse mid-stream with in=1 -> out = 0 the following cycle. Next update is 256+1 cycles after release. Exact 16777216 returns from the 4th update after release.

Source files
------------

// File: rtl/cic3_decimator_pkg.sv
// cic3_pkg: shared constants, data word type and monitor select codes for the
// third-order CIC decimator.
//   ORDER      - number of integrator / comb stages (design is written for 3)
//   DECIM_LOG2 - log2 of the decimation ratio
//   OUT_W      - accumulator / output width, 1 + ORDER*DECIM_LOG2
//   R          - decimation ratio
package cic3_pkg;

    localparam int ORDER      = 3;
    localparam int DECIM_LOG2 = 8;
    localparam int OUT_W      = 1 + ORDER * DECIM_LOG2;
    localparam int R          = 1 << DECIM_LOG2;

    typedef logic [OUT_W-1:0] cic_word_t;

    // Debug monitor routing; codes 9..15 are unused and read as zero.
    typedef enum logic [3:0] {
        MON_OUT = 4'd0,
        MON_I1  = 4'd1,
        MON_I2  = 4'd2,
        MON_I3  = 4'd3,
        MON_D1  = 4'd4,
        MON_D2  = 4'd5,
        MON_D3  = 4'd6,
        MON_CNT = 4'd7,
        MON_IN  = 4'd8
    } mon_sel_e;

endpackage

// File: rtl/cic3_decimator_integrator.sv
// cic_integrator: one running-sum stage of the CIC integrator chain.
// Ports:
//   clk   - system clock (modulator rate)
//   reset - synchronous active-high clear
//   din   - value added every cycle (previous stage's registered sum)
//   acc   - registered running sum, wraps modulo 2^OUT_W
module cic_integrator
    import cic3_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [OUT_W-1:0] din,
    output logic [OUT_W-1:0] acc
);

    logic [OUT_W-1:0] acc_reg;

    // Modulo wrap is intentional: the comb differences cancel the overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_reg + din;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/cic3_decimator.sv
// cic3_decimator: sinc^3 decimation filter (R = 256, M = 1) for a 1-bit
// sigma-delta bitstream, with a registered debug monitor on the output bus.
// Ports:
//   clk                 - system clock, one input bit per cycle
//   reset               - synchronous active-high clear of all filter state
//   in                  - modulator bit, 1 = full scale, 0 = zero
//   digital_monitor_sel - selects filter output or an internal node for out
//   out                 - registered, unsigned selected data (OUT_W bits)
module cic3_decimator
    import cic3_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic [3:0]       digital_monitor_sel,
    output logic [OUT_W-1:0] out
);

    // stage[0] is the zero-extended input bit, stage[k] the k-th integrator.
    logic [OUT_W-1:0]      stage [0:ORDER];
    logic [DECIM_LOG2-1:0] cnt_reg;
    logic [OUT_W-1:0]      d1_reg;
    logic [OUT_W-1:0]      d2_reg;
    logic [OUT_W-1:0]      d3_reg;
    logic [OUT_W-1:0]      y_reg;
    logic [OUT_W-1:0]      out_reg;
    logic [OUT_W-1:0]      c1;
    logic [OUT_W-1:0]      c2;
    logic [OUT_W-1:0]      c3;
    logic [OUT_W-1:0]      out_next;
    logic                  strobe;
    mon_sel_e              sel_code;

    assign stage[0] = {{(OUT_W-1){1'b0}}, in};

    genvar gi;
    generate
        for (gi = 0; gi < ORDER; gi++) begin : g_integ
            cic_integrator u_integ (
                .clk   (clk),
                .reset (reset),
                .din   (stage[gi]),
                .acc   (stage[gi+1])
            );
        end
    endgenerate

    // Last cycle of each 256-cycle frame; combs run on this edge.
    assign strobe = (cnt_reg == {DECIM_LOG2{1'b1}});

    // Comb chain at the decimated rate, all modulo 2^OUT_W.
    always_comb begin
        c1 = stage[ORDER] - d1_reg;
        c2 = c1 - d2_reg;
        c3 = c2 - d3_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
            d1_reg  <= '0;
            d2_reg  <= '0;
            d3_reg  <= '0;
            y_reg   <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (strobe) begin
                d1_reg <= stage[ORDER];
                d2_reg <= c1;
                d3_reg <= c2;
                y_reg  <= c3;
            end
        end
    end

    assign sel_code = mon_sel_e'(digital_monitor_sel);

    always_comb begin
        out_next = '0;
        case (sel_code)
            MON_OUT: out_next = y_reg;
            MON_I1:  out_next = stage[1];
            MON_I2:  out_next = stage[2];
            MON_I3:  out_next = stage[3];
            MON_D1:  out_next = d1_reg;
            MON_D2:  out_next = d2_reg;
            MON_D3:  out_next = d3_reg;
            MON_CNT: out_next = {{(OUT_W-DECIM_LOG2){1'b0}}, cnt_reg};
            MON_IN:  out_next = stage[0];
            default: out_next = '0;
        endcase
    end

    // The bus is registered so a select change lands cleanly on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg <= '0;
        end else begin
            out_reg <= out_next;
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_cic3_decimator.sv
// Testbench for cic3_decimator: directed steps with an expected-sample queue.
module tb_cic3_decimator;

    localparam int W = 25;

    logic         clk = 1'b0;
    logic         reset;
    logic         in;
    logic [3:0]   sel;
    logic [W-1:0] out;

    int  errors = 0;
    int  checks = 0;
    int  t = 0;
    real sd_acc = 0.0;
    real sine_sum = 0.0;
    int  sine_n = 0;
    longint sine_min = 64'sd1 << 40;
    longint sine_max = 0;

    typedef struct {
        int           idx;
        logic [W-1:0] val;
    } exp_t;

    exp_t exp_q[$];

    always #10 clk = ~clk;

    cic3_decimator dut (
        .clk                 (clk),
        .reset               (reset),
        .in                  (in),
        .digital_monitor_sel (sel),
        .out                 (out)
    );

    function automatic logic [W-1:0] w25(input longint v);
        return v[W-1:0];
    endfunction

    // C(s,3): third integrator value after s edges of constant input 1.
    function automatic longint binom3(input longint s);
        if (s < 3) return 0;
        return s * (s - 1) * (s - 2) / 6;
    endfunction

    // Third integrator as seen at the m-th strobe (edge 256*m).
    function automatic longint i3_at(input int m);
        if (m <= 0) return 0;
        return binom3(longint'(m) * 256 - 1);
    endfunction

    // Expected n-th decimated sample for constant in=1: third difference.
    function automatic logic [W-1:0] y_const(input int n);
        return w25(i3_at(n) - 3 * i3_at(n - 1) + 3 * i3_at(n - 2) - i3_at(n - 3));
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (t=%0d)", tag, got, expv, t);
        end
    endtask

    task automatic check_range(input string tag, input longint got, input longint lo, input longint hi);
        checks++;
        assert (got >= lo && got <= hi) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected range [%0d,%0d]", tag, got, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        t = 0;
    endtask

    // mode: 0 zeros, 1 ones, 2 alternating, 3 sigma-delta sine.
    // Runs n_upd frames after a reset and compares out against the queue.
    task automatic run_stream(input int mode, input int n_upd, input string tag);
        exp_t cur;
        bit   have;
        int   upd;
        real  u;
        real  v;
        have = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].idx == 0) begin
            cur  = exp_q.pop_front();
            have = 1'b1;
        end
        for (int k = 0; k < n_upd * 256 + 1; k++) begin
            case (mode)
                0: in = 1'b0;
                1: in = 1'b1;
                2: in = ((t % 2) == 0);
                default: begin
                    u = 0.5 + 0.45 * $sin(2.0 * 3.14159265358979 * real'(t + 1) / 8192.0);
                    v = sd_acc + u;
                    if (v >= 1.0) begin
                        in = 1'b1;
                        sd_acc = v - 1.0;
                    end else begin
                        in = 1'b0;
                        sd_acc = v;
                    end
                end
            endcase
            tick();
            if (t >= 257 && ((t - 1) % 256) == 0) begin
                upd  = (t - 1) / 256;
                have = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].idx == upd) begin
                    cur  = exp_q.pop_front();
                    have = 1'b1;
                end
                $display("%s update %0d at t=%0d out=%0d", tag, upd, t, out);
                if (mode == 3 && upd >= 4) begin
                    check_range("sine_bound", longint'(out), 0, 64'sd1 << 24);
                    if (upd >= 5) begin
                        sine_sum += real'(out);
                        sine_n++;
                        if (longint'(out) < sine_min) sine_min = longint'(out);
                        if (longint'(out) > sine_max) sine_max = longint'(out);
                    end
                end
            end
            if (have) check(tag, out, cur.val);
        end
        check({tag, "_queue_drained"}, W'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        in    = 1'b0;
        sel   = 4'd0;

        // Reset state.
        do_reset(3);
        check("reset_out", out, '0);

        // All-zero input: out stays zero for ~5000 cycles.
        for (int n = 0; n <= 20; n++) exp_q.push_back('{idx: n, val: '0});
        run_stream(0, 20, "zero");

        // Constant ones: exact transient samples, then 2^24 from update 4.
        do_reset(2);
        for (int n = 0; n <= 8; n++) exp_q.push_back('{idx: n, val: y_const(n)});
        run_stream(1, 8, "const1");

        // Reset clears the bus for every select value.
        reset = 1'b1;
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            tick();
            check("reset_sel", out, '0);
        end
        reset = 1'b0;
        sel   = 4'd0;
        t     = 0;

        // Alternating 1,0: steady state 2^23 from update 4.
        exp_q.push_back('{idx: 0, val: '0});
        for (int n = 4; n <= 8; n++) exp_q.push_back('{idx: n, val: 25'd8388608});
        run_stream(2, 8, "alt");

        // Monitor selects with constant ones.
        do_reset(2);
        in = 1'b1;
        sel = 4'd7;
        for (int k = 0; k < 300; k++) begin
            tick();
            check("mon_cnt", out, w25((t - 1) % 256));
        end
        sel = 4'd1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("mon_i1", out, w25(t - 1));
        end
        sel = 4'd2;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("mon_i2", out, w25(longint'(t - 1) * (t - 2) / 2));
        end
        sel = 4'd3;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("mon_i3", out, w25(binom3(t - 1)));
        end
        for (int s = 4; s <= 6; s++) begin
            sel = 4'(s);
            repeat (2) begin
                tick();
                check("mon_delay", out, w25(binom3(255)));
            end
        end
        sel = 4'd0;
        repeat (2) begin
            tick();
            check("mon_y", out, y_const(1));
        end
        for (int s = 9; s < 16; s++) begin
            sel = 4'(s);
            tick();
            check("mon_unused", out, '0);
        end
        sel = 4'd8;
        for (int k = 0; k < 6; k++) begin
            in = k[0];
            tick();
            check("mon_in", out, w25(longint'(k[0])));
        end
        sel = 4'd0;

        // Reset pulse mid-stream: immediate clear, first update 257 edges later.
        do_reset(2);
        in = 1'b1;
        repeat (600) tick();
        reset = 1'b1;
        tick();
        check("midreset_out", out, '0);
        reset = 1'b0;
        t = 0;
        for (int n = 0; n <= 6; n++) exp_q.push_back('{idx: n, val: y_const(n)});
        run_stream(1, 6, "midreset");

        // Sigma-delta sine: bounded, centred near 2^23, full swing.
        do_reset(2);
        sd_acc = 0.0;
        exp_q.push_back('{idx: 0, val: '0});
        run_stream(3, 68, "sine");
        check_range("sine_mean", longint'(sine_sum / real'(sine_n)),
                    (64'sd1 << 23) - (64'sd1 << 21), (64'sd1 << 23) + (64'sd1 << 21));
        check_range("sine_max", sine_max, (64'sd1 << 23) + (64'sd1 << 22), 64'sd1 << 24);
        check_range("sine_min", sine_min, 0, (64'sd1 << 23) - (64'sd1 << 22));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
